// File: rtl/alu_seq.sv
// alu_seq: flag-registering ALU for the ARMv4 datapath.
// Single-cycle ADD/SUB/AND/ORR/EOR/ADC/SBC. MUL is a shift-add multiply
// that retires one multiplier bit per clock and holds busy while it runs.
// All outputs come straight from registers.

module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             setflags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    // Opcode encoding
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_ADC = 3'b110;
    localparam logic [2:0] OP_SBC = 3'b111;

    // Iteration counter sizing: counts 0..WIDTH-1
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MULT = 1'b1
    } state_t;

    // Architectural and control state
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;    // multiplicand, shifted left once per iteration
    logic [WIDTH-1:0] mplier_q;   // multiplier, shifted right once per iteration
    logic [WIDTH-1:0] acc_q;
    logic             mul_sf_q;   // setflags captured when the MUL was accepted
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             busy_q;
    logic             done_q;

    // Next-state values for the single-cycle datapath and the MUL step
    logic [WIDTH-1:0] b_eff_d;
    logic             cin_d;
    logic             arith_d;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] alu_res_d;
    logic             alu_c_d;
    logic             alu_v_d;
    logic [3:0]       alu_flags_d;
    logic [WIDTH-1:0] acc_d;
    logic [3:0]       mul_flags_d;

    // Operand selection for the adder: subtraction uses the inverted operand,
    // and the carry-in comes from the stored C flag for ADC/SBC.
    always_comb begin
        b_eff_d = b;
        cin_d   = 1'b0;
        arith_d = 1'b0;
        case (op)
            OP_ADD: begin
                b_eff_d = b;
                cin_d   = 1'b0;
                arith_d = 1'b1;
            end
            OP_SUB: begin
                b_eff_d = ~b;
                cin_d   = 1'b1;
                arith_d = 1'b1;
            end
            OP_ADC: begin
                b_eff_d = b;
                cin_d   = flags_q[1];
                arith_d = 1'b1;
            end
            OP_SBC: begin
                b_eff_d = ~b;
                cin_d   = flags_q[1];
                arith_d = 1'b1;
            end
            default: begin
                b_eff_d = b;
                cin_d   = 1'b0;
                arith_d = 1'b0;
            end
        endcase
    end

    // Single-cycle result and the flags it would produce
    always_comb begin
        sum_d     = {1'b0, a} + {1'b0, b_eff_d} + {{WIDTH{1'b0}}, cin_d};
        alu_res_d = sum_d[WIDTH-1:0];
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
        case (op)
            OP_AND:  alu_res_d = a & b;
            OP_ORR:  alu_res_d = a | b;
            OP_EOR:  alu_res_d = a ^ b;
            default: alu_res_d = sum_d[WIDTH-1:0];
        endcase
        if (arith_d) begin
            alu_c_d = sum_d[WIDTH];
            alu_v_d = (a[WIDTH-1] == b_eff_d[WIDTH-1]) &&
                      (sum_d[WIDTH-1] != a[WIDTH-1]);
        end else begin
            alu_c_d = 1'b0;
            alu_v_d = 1'b0;
        end
        alu_flags_d = {alu_res_d[WIDTH-1], (alu_res_d == ZERO_W), alu_c_d, alu_v_d};
    end

    // One shift-add step; MUL leaves C and V as they were
    always_comb begin
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
        mul_flags_d = {acc_d[WIDTH-1], (acc_d == ZERO_W), flags_q[1:0]};
    end

    // Control FSM plus all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            mcand_q  <= ZERO_W;
            mplier_q <= ZERO_W;
            acc_q    <= ZERO_W;
            mul_sf_q <= 1'b0;
            result_q <= ZERO_W;
            flags_q  <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (op == OP_MUL) begin
                            state_q  <= ST_MULT;
                            mcand_q  <= a;
                            mplier_q <= b;
                            acc_q    <= ZERO_W;
                            cnt_q    <= CNT_ZERO;
                            mul_sf_q <= setflags;
                            busy_q   <= 1'b1;
                        end else begin
                            result_q <= alu_res_d;
                            done_q   <= 1'b1;
                            if (setflags) begin
                                flags_q <= alu_flags_d;
                            end
                        end
                    end
                end
                ST_MULT: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
                        cnt_q    <= CNT_ZERO;
                        if (mul_sf_q) begin
                            flags_q <= mul_flags_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    cnt_q   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed vector table,
// hand-written MUL timing/abort sequences, and randomized ops against a
// plain-arithmetic reference model.

module tb_alu_seq;

    localparam int WIDTH = 32;

    logic              clk;
    logic              reset;
    logic              start_i;
    logic [2:0]        op_i;
    logic              sf_i;
    logic [WIDTH-1:0]  a_i;
    logic [WIDTH-1:0]  b_i;
    logic [WIDTH-1:0]  result_o;
    logic [3:0]        flags_o;
    logic              busy_o;
    logic              done_o;

    int n_pass  = 0;
    int n_total = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start_i),
        .op       (op_i),
        .setflags (sf_i),
        .a        (a_i),
        .b        (b_i),
        .result   (result_o),
        .flags    (flags_o),
        .busy     (busy_o),
        .done     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sf;
        logic [31:0] exp_res;
        logic [3:0]  exp_nzcv;
    } vec_t;

    localparam longint S_MAX = 64'sh7FFFFFFF;
    localparam longint S_MIN = -64'sh80000000;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: returns {nzcv, result} from true integer arithmetic.
    function automatic logic [35:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input logic [3:0] fl,
                                           input logic sf);
        longint unsigned ux, uy, u;
        longint sx, sy, s;
        logic [31:0] r;
        logic c, v, ci;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ci = fl[1];
        c  = fl[1];
        v  = fl[0];
        u  = 64'd0;
        s  = 64'sd0;
        r  = 32'd0;
        case (o)
            3'd0: begin
                u = ux + uy;            r = u[31:0];
                c = (u > 64'hFFFFFFFF); s = sx + sy; v = (s > S_MAX) || (s < S_MIN);
            end
            3'd1: begin
                r = x - y; c = (ux >= uy);
                s = sx - sy; v = (s > S_MAX) || (s < S_MIN);
            end
            3'd6: begin
                u = ux + uy + (ci ? 64'd1 : 64'd0); r = u[31:0];
                c = (u > 64'hFFFFFFFF);
                s = sx + sy + (ci ? 64'sd1 : 64'sd0); v = (s > S_MAX) || (s < S_MIN);
            end
            3'd7: begin
                u = ux - uy - (ci ? 64'd0 : 64'd1); r = u[31:0];
                c = (ux >= uy + (ci ? 64'd0 : 64'd1));
                s = sx - sy - (ci ? 64'sd0 : 64'sd1); v = (s > S_MAX) || (s < S_MIN);
            end
            3'd2: begin r = x & y; c = 1'b0; v = 1'b0; end
            3'd3: begin r = x | y; c = 1'b0; v = 1'b0; end
            3'd4: begin r = x ^ y; c = 1'b0; v = 1'b0; end
            default: begin
                u = ux * uy; r = u[31:0];
            end
        endcase
        if (sf) begin
            return {r[31], (r == 32'd0), c, v, r};
        end else begin
            return {fl, r};
        end
    endfunction

    // Issue one op at a negedge; return at the negedge where done is seen.
    task automatic run_op(input logic [2:0] o, input logic [31:0] oa, input logic [31:0] ob,
                          input logic osf, output logic [31:0] r, output logic [3:0] f,
                          output int lat, output logic ok);
        op_i = o; a_i = oa; b_i = ob; sf_i = osf; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        ok  = 1'b0;
        lat = -1;
        for (int c = 0; c < WIDTH + 4; c++) begin
            if (done_o) begin
                ok  = 1'b1;
                lat = c;
                break;
            end
            @(negedge clk);
        end
        r = result_o;
        f = flags_o;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[13];
    logic [31:0] corn[5];

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        logic        ok;
        int          lat;
        int          busy_cnt;
        logic        early_done;
        logic        stray_done;
        logic [3:0]  flags_m;
        logic [35:0] m;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic        rsf;

        reset = 1'b1; start_i = 1'b0; op_i = 3'd0; sf_i = 1'b0;
        a_i = 32'd0; b_i = 32'd0;

        vecs[0]  = '{3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 4'b1001};
        vecs[1]  = '{3'd1, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 4'b0110};
        vecs[2]  = '{3'd2, 32'h000000F0, 32'h0000000F, 1'b1, 32'h00000000, 4'b0100};
        vecs[3]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 4'b0110};
        vecs[4]  = '{3'd6, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 4'b0000};
        vecs[5]  = '{3'd7, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 4'b0000};
        vecs[6]  = '{3'd3, 32'h000000F0, 32'h00000F00, 1'b1, 32'h00000FF0, 4'b0000};
        vecs[7]  = '{3'd4, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'b1000};
        vecs[8]  = '{3'd1, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 4'b1000};
        vecs[9]  = '{3'd1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 4'b0011};
        vecs[10] = '{3'd0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0011};
        vecs[11] = '{3'd7, 32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 4'b0010};
        vecs[12] = '{3'd5, 32'h0000FFFF, 32'h00010001, 1'b1, 32'hFFFFFFFF, 4'b1010};
        corn[0] = 32'h00000000; corn[1] = 32'h00000001; corn[2] = 32'h7FFFFFFF;
        corn[3] = 32'h80000000; corn[4] = 32'hFFFFFFFF;

        // Reset state
        do_reset();
        chk("reset_result", {32'd0, result_o}, 64'd0);
        chk("reset_flags",  {60'd0, flags_o},  64'd0);
        chk("reset_busy",   {63'd0, busy_o},   64'd0);
        chk("reset_done",   {63'd0, done_o},   64'd0);

        // Directed vector table (flags carry from one vector to the next)
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf, r, f, lat, ok);
            chk($sformatf("vec%0d_done", i),   {63'd0, ok}, 64'd1);
            chk($sformatf("vec%0d_lat", i),    64'(lat), (vecs[i].op == 3'd5) ? 64'd32 : 64'd0);
            chk($sformatf("vec%0d_result", i), {32'd0, r}, {32'd0, vecs[i].exp_res});
            chk($sformatf("vec%0d_nzcv", i),   {60'd0, f},  {60'd0, vecs[i].exp_nzcv});
        end

        // MUL timing with C set, start during busy ignored, start in done cycle accepted
        do_reset();
        run_op(3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b1, r, f, lat, ok);
        chk("pre_mul_flags", {60'd0, f}, {60'd0, 4'b0110});
        op_i = 3'd5; a_i = 32'h0000FFFF; b_i = 32'h00010001; sf_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        busy_cnt = 0;
        early_done = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (busy_o) busy_cnt++;
            if (done_o) early_done = 1'b1;
            if (i == 5) begin
                start_i = 1'b1; op_i = 3'd0; a_i = 32'd1; b_i = 32'd1; sf_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
        end
        chk("mul_busy_cycles", 64'(busy_cnt), 64'd32);
        chk("mul_early_done",  {63'd0, early_done}, 64'd0);
        chk("mul_done",        {63'd0, done_o}, 64'd1);
        chk("mul_busy_end",    {63'd0, busy_o}, 64'd0);
        chk("mul_result",      {32'd0, result_o}, {32'd0, 32'hFFFFFFFF});
        chk("mul_nzcv",        {60'd0, flags_o}, {60'd0, 4'b1010});
        run_op(3'd0, 32'd2, 32'd3, 1'b0, r, f, lat, ok);
        chk("done_cycle_start_lat", 64'(lat), 64'd0);
        chk("done_cycle_start_res", {32'd0, r}, 64'd5);
        chk("done_cycle_start_nzcv", {60'd0, f}, {60'd0, 4'b1010});

        // Reset during MUL aborts it
        op_i = 3'd5; a_i = 32'd3; b_i = 32'd4; sf_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_result", {32'd0, result_o}, 64'd0);
        chk("abort_flags",  {60'd0, flags_o},  64'd0);
        chk("abort_busy",   {63'd0, busy_o},   64'd0);
        chk("abort_done",   {63'd0, done_o},   64'd0);
        run_op(3'd0, 32'd2, 32'd3, 1'b1, r, f, lat, ok);
        chk("abort_add_res",  {32'd0, r}, 64'd5);
        chk("abort_add_nzcv", {60'd0, f}, 64'd0);
        @(negedge clk);
        stray_done = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (done_o) stray_done = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_stray_done", {63'd0, stray_done}, 64'd0);

        // Randomized ops against the reference model
        do_reset();
        flags_m = 4'b0000;
        for (int i = 0; i < 60; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? corn[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corn[$urandom_range(0, 4)] : $urandom;
            rsf = ($urandom_range(0, 3) != 0);
            m = ref_op(ro, ra, rb, flags_m, rsf);
            run_op(ro, ra, rb, rsf, r, f, lat, ok);
            chk($sformatf("rnd%0d_op%0d_done", i, ro), {63'd0, ok}, 64'd1);
            chk($sformatf("rnd%0d_op%0d_result", i, ro), {32'd0, r}, {32'd0, m[31:0]});
            chk($sformatf("rnd%0d_op%0d_nzcv", i, ro), {60'd0, f}, {60'd0, m[35:32]});
            flags_m = m[35:32];
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
